// File: rtl/tb_harness_pkg.sv
// Shared FSM state encoding and the default write-trace entry layout for regfile_scan_checker.
package tb_harness_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_RUN   = 3'd1;
    localparam state_t ST_ISSUE = 3'd2;
    localparam state_t ST_CHECK = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    localparam int DEF_CYC_W  = 21;
    localparam int DEF_REG_W  = 5;
    localparam int DEF_DATA_W = 32;

    // Field order matches the packed {cyc, rd, data} word on trace_data.
    typedef struct packed {
        logic [DEF_CYC_W-1:0]  cyc;
        logic [DEF_REG_W-1:0]  rd;
        logic [DEF_DATA_W-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous write-trace FIFO; head is visible the cycle after a push, popped on pop_vld && pop_rdy.
// A push is accepted when not full, or when full and popping in the same cycle; clr empties it.
module trace_fifo #(
    parameter int W     = 58,
    parameter int DEPTH = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         clr,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop_rdy,
    output logic         pop_vld,
    output logic [W-1:0] pop_dat,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
    logic [W-1:0] mem_q [DEPTH];
    logic         empty, push_ok, pop_ok;

    // Extra pointer MSB separates full from empty when the indices coincide.
    assign empty   = (wr_q == rd_q);
    assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop_vld = !empty;
    assign pop_dat = mem_q[rd_q[AW-1:0]];
    assign pop_ok  = pop_vld && pop_rdy;
    assign push_ok = push_vld && (!full || pop_ok);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (clr) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_ok) wr_d = wr_q + (AW+1)'(1);
            if (pop_ok)  rd_d = rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok && !clr) mem_q[wr_q[AW-1:0]] <= push_dat;
    end

endmodule

// File: rtl/regfile_scan_checker.sv
// Runs the CPU for num_cycles, then scans every register against an expected-value ROM (2 cycles/reg).
// Optional write trace under WRITE_TRACE_EN; trace pops on trace_valid && trace_ready.
module regfile_scan_checker
    import tb_harness_pkg::*;
#(
    parameter int NUM_REGS    = 32,
    parameter int DATA_W      = 32,
    parameter int CYC_W       = 21,
    parameter int TRACE_DEPTH = 8,
    localparam int REG_W      = $clog2(NUM_REGS)
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            start,
    input  logic [CYC_W-1:0]                num_cycles,
    input  logic                            rwe,
    input  logic [REG_W-1:0]                rd,
    input  logic [DATA_W-1:0]               rdata,
    output logic                            test_mode,
    output logic [REG_W-1:0]                test_reg,
    input  logic [DATA_W-1:0]               reg_val,
    output logic [REG_W-1:0]                exp_addr,
    input  logic [DATA_W-1:0]               exp_data,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [REG_W:0]                  errors,
    output logic [REG_W-1:0]                fail_reg,
    output logic [DATA_W-1:0]               fail_exp,
    output logic [DATA_W-1:0]               fail_act,
    output logic                            trace_valid,
    input  logic                            trace_ready,
    output logic [CYC_W+REG_W+DATA_W-1:0]   trace_data,
    output logic                            trace_overflow
);
    localparam logic [REG_W-1:0] LAST_REG = REG_W'(NUM_REGS - 1);
    localparam logic [REG_W:0]   ERR_MAX  = (REG_W+1)'(NUM_REGS);

    state_t              state_q, state_d;
    logic [CYC_W-1:0]    cyc_q, cyc_d, num_q, num_d;
    logic [REG_W-1:0]    k_q, k_d, fail_reg_q, fail_reg_d;
    logic [REG_W:0]      err_q, err_d;
    logic [DATA_W-1:0]   fail_exp_q, fail_exp_d, fail_act_q, fail_act_d;
    logic                start_ok, mismatch, run_last;

    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign mismatch = (reg_val !== exp_data);
    assign run_last = (cyc_q == num_q - CYC_W'(1));

    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        num_d      = num_q;
        k_d        = k_q;
        err_d      = err_q;
        fail_reg_d = fail_reg_q;
        fail_exp_d = fail_exp_q;
        fail_act_d = fail_act_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_d    = (num_cycles == '0) ? ST_ISSUE : ST_RUN;
                    num_d      = num_cycles;
                    cyc_d      = '0;
                    k_d        = '0;
                    err_d      = '0;
                    fail_reg_d = '0;
                    fail_exp_d = '0;
                    fail_act_d = '0;
                end
            end
            ST_RUN: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (run_last) state_d = ST_ISSUE;
            end
            ST_ISSUE: state_d = ST_CHECK;
            ST_CHECK: begin
                // exp_data arrives one cycle after exp_addr, so the compare happens here, not in ISSUE.
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + (REG_W+1)'(1);
                    if (err_q == '0) begin
                        fail_reg_d = k_q;
                        fail_exp_d = exp_data;
                        fail_act_d = reg_val;
                    end
                end
                if (k_q == LAST_REG) begin
                    state_d = ST_DONE;
                    k_d     = '0;
                end else begin
                    state_d = ST_ISSUE;
                    k_d     = k_q + REG_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cyc_q      <= '0;
            num_q      <= '0;
            k_q        <= '0;
            err_q      <= '0;
            fail_reg_q <= '0;
            fail_exp_q <= '0;
            fail_act_q <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            num_q      <= num_d;
            k_q        <= k_d;
            err_q      <= err_d;
            fail_reg_q <= fail_reg_d;
            fail_exp_q <= fail_exp_d;
            fail_act_q <= fail_act_d;
        end
    end

    assign test_mode = (state_q == ST_ISSUE) || (state_q == ST_CHECK);
    assign test_reg  = k_q;
    assign exp_addr  = k_q;
    assign busy      = (state_q == ST_RUN) || test_mode;
    assign done      = (state_q == ST_DONE);
    assign pass      = done && (err_q == '0);
    assign errors    = err_q;
    assign fail_reg  = fail_reg_q;
    assign fail_exp  = fail_exp_q;
    assign fail_act  = fail_act_q;

`ifdef WRITE_TRACE_EN
    localparam int TW = CYC_W + REG_W + DATA_W;

    logic trace_push, trace_pop, fifo_full, ovf_q, ovf_d;

    assign trace_push = (state_q == ST_RUN) && rwe && (rd != '0);
    assign trace_pop  = trace_valid && trace_ready;

    trace_fifo #(
        .W     (TW),
        .DEPTH (TRACE_DEPTH)
    ) u_trace_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .clr      (start_ok),
        .push_vld (trace_push),
        .push_dat ({cyc_q, rd, rdata}),
        .pop_rdy  (trace_ready),
        .pop_vld  (trace_valid),
        .pop_dat  (trace_data),
        .full     (fifo_full)
    );

    always_comb begin
        ovf_d = ovf_q;
        if (start_ok) ovf_d = 1'b0;
        else if (trace_push && fifo_full && !trace_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    assign trace_overflow = ovf_q;
`else
    logic unused_trace;
    assign unused_trace   = ^{trace_ready, rwe, rd, rdata};
    assign trace_valid    = 1'b0;
    assign trace_data     = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule
